// File: rtl/nv_ram_pkg.sv
// Shared types for the parametrised 1R1W RAM model: init FSM encoding and
// an elaboration-time clog2 used for the AW/DEPTH legality check.
package nv_ram_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RDY  = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nv_ram_init_ctl.sv
// Post-reset zero-fill sequencer: sweeps 0..DEPTH-1 once, then raises
// init_done one edge after the last write and stays ready until reset.
module nv_ram_init_ctl
    import nv_ram_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int AW        = 8,
    parameter int INIT_ZERO = 0
) (
    input  logic          clk,
    input  logic          rstn,
    output logic          init_done,
    output logic          init_we,
    output logic [AW-1:0] init_wa
);

    localparam state_e        RST_ST = (INIT_ZERO != 0) ? S_INIT : S_RDY;
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            S_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_RDY;
                    cnt_d   = '0;
                end
            end
            S_RDY: begin
                state_d = S_RDY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RST_ST;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == S_RDY);
        end
    end

    assign init_done = done_q;
    assign init_wa   = cnt_q;

endmodule

// File: rtl/nv_ram_rwst_param.sv
// Parametrised 1R1W RAM with registered read address, read-valid flag and
// range protection; NV_RAM_RWST_DOUT_FLOP_EN adds a dout output register.
module nv_ram_rwst_param
    import nv_ram_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int WIDTH     = 8,
    parameter int AW        = 8,
    parameter int INIT_ZERO = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    output logic             init_done,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam int          IW      = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    if (clog2(DEPTH) > AW || DEPTH < 2 || WIDTH < 1) begin : g_param_chk
        $error("nv_ram_rwst_param: illegal DEPTH/WIDTH/AW combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra_q;
    logic             vld_q;
    logic             init_we;
    logic [AW-1:0]    init_wa;
    logic             re_g, we_g;
    logic             ra_ok, wa_ok;
    logic [WIDTH-1:0] rd_data;
    logic             unused_pd;

    nv_ram_init_ctl #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_ZERO (INIT_ZERO)
    ) u_init (
        .clk       (clk),
        .rstn      (rstn),
        .init_done (init_done),
        .init_we   (init_we),
        .init_wa   (init_wa)
    );

    assign wa_ok = ({1'b0, wa} < DEPTH_W);
    assign ra_ok = ({1'b0, ra_q} < DEPTH_W);
    assign re_g  = re & init_done;
    assign we_g  = we & init_done & wa_ok;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_wa[IW-1:0]] <= '0;
        end else if (we_g) begin
            mem[wa[IW-1:0]] <= di;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ra_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            if (re_g) begin
                ra_q <= ra;
            end
            vld_q <= re_g;
        end
    end

    assign rd_data = ra_ok ? mem[ra_q[IW-1:0]] : '0;

`ifdef NV_RAM_RWST_DOUT_FLOP_EN
    logic [WIDTH-1:0] dout_q;
    logic             vld2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q <= '0;
            vld2_q <= 1'b0;
        end else begin
            if (vld_q) begin
                dout_q <= rd_data;
            end
            vld2_q <= vld_q;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld2_q;
`else
    assign dout     = rd_data;
    assign dout_vld = vld_q;
`endif

    assign unused_pd = ^pwrbus_ram_pd;

endmodule

// File: tb/tb_nv_ram_rwst_param.sv
// Scoreboard bench for nv_ram_rwst_param: three instances (256 plain,
// 200 out-of-range, 16 zero-fill) driven by directed vectors.
module tb_nv_ram_rwst_param;

    localparam int N = 3;
`ifdef NV_RAM_RWST_DOUT_FLOP_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    function automatic int dep_of(input int g);
        case (g)
            0:       return 256;
            1:       return 200;
            default: return 16;
        endcase
    endfunction

    typedef struct packed {
        logic [7:0] d;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       re_s [N];
    logic       we_s [N];
    logic [7:0] ra_s [N];
    logic [7:0] wa_s [N];
    logic [7:0] di_s [N];
    logic [7:0] dout_s [N];
    logic       vld_s [N];
    logic       done_s [N];
    logic [31:0] pd = 32'h0;

    exp_t       sb [N][$];
    logic [7:0] mdl [N][256];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int run0 = 0;
    int max0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        nv_ram_rwst_param #(
            .DEPTH     (dep_of(g)),
            .WIDTH     (8),
            .AW        (8),
            .INIT_ZERO ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk           (clk),
            .rstn          (rstn),
            .ra            (ra_s[g]),
            .re            (re_s[g]),
            .dout          (dout_s[g]),
            .dout_vld      (vld_s[g]),
            .wa            (wa_s[g]),
            .we            (we_s[g]),
            .di            (di_s[g]),
            .init_done     (done_s[g]),
            .pwrbus_ram_pd (pd)
        );

        always @(negedge clk) begin
            exp_t e;
            if (vld_s[g]) begin
                chk($sformatf("sb_has_entry[%0d]", g),
                    32'(sb[g].size() != 0), 32'd1);
                if (sb[g].size() != 0) begin
                    e = sb[g].pop_front();
                    chk($sformatf("dout[%0d]", g), 32'(dout_s[g]), 32'(e.d));
                    chk($sformatf("latency[%0d]", g), 32'(cyc - e.c), 32'(LAT));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (vld_s[0]) begin
            run0++;
            if (run0 > max0) max0 = run0;
        end else begin
            run0 = 0;
        end
    end

    task automatic clr();
        for (int k = 0; k < N; k++) begin
            re_s[k] = 1'b0;
            we_s[k] = 1'b0;
            ra_s[k] = 8'h00;
            wa_s[k] = 8'h00;
            di_s[k] = 8'h00;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clr();
        end
    endtask

    task automatic op(input int g, input bit r, input logic [7:0] ra,
                      input bit w, input logic [7:0] wa,
                      input logic [7:0] di, input bit acc);
        @(negedge clk);
        clr();
        re_s[g] = r;
        ra_s[g] = ra;
        we_s[g] = w;
        wa_s[g] = wa;
        di_s[g] = di;
        if (acc && w && (int'(wa) < dep_of(g))) mdl[g][wa] = di;
        if (acc && r)
            sb[g].push_back(exp_t'{
                (int'(ra) < dep_of(g)) ? mdl[g][ra] : 8'h00, cyc});
    endtask

    initial begin
        int n;
        clr();
        for (int a = 0; a < 256; a++) mdl[2][a] = 8'h00;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("rst_vld[%0d]", g), 32'(vld_s[g]), 32'd0);
            chk($sformatf("rst_done[%0d]", g), 32'(done_s[g]), 32'd0);
        end

        // sweep interrupted at address 7, then restarted with traffic held
        rstn = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("done_mid_rst", 32'(done_s[2]), 32'd0);
        @(negedge clk);
        re_s[2] = 1'b1;
        we_s[2] = 1'b1;
        ra_s[2] = 8'h03;
        wa_s[2] = 8'h03;
        di_s[2] = 8'h55;
        rstn = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                chk("done_noinit_a", 32'(done_s[0]), 32'd1);
                chk("done_noinit_b", 32'(done_s[1]), 32'd1);
                chk("done_init_early", 32'(done_s[2]), 32'd0);
            end
            if (done_s[2]) break;
        end
        clr();
        chk("init_edges", 32'(n), 32'd17);
        chk("vld_during_init", 32'(vld_s[2]), 32'd0);

        for (int a = 0; a < 16; a++) op(2, 1, 8'(a), 0, 8'h00, 8'h00, 1);
        op(2, 0, 8'h00, 1, 8'h05, 8'h9C, 1);
        op(2, 1, 8'h05, 0, 8'h00, 8'h00, 1);
        op(2, 1, 8'hF0, 1, 8'hF0, 8'h66, 1);
        idle(2);

        op(0, 0, 8'h00, 1, 8'h10, 8'hA5, 1);
        op(0, 1, 8'h10, 0, 8'h00, 8'h00, 1);
        idle(1);
        op(0, 0, 8'h00, 1, 8'h20, 8'h11, 1);
        op(0, 1, 8'h20, 1, 8'h20, 8'h3C, 1);
        idle(2);
`ifndef NV_RAM_RWST_DOUT_FLOP_EN
        op(0, 0, 8'h00, 1, 8'h20, 8'h77, 1);
        idle(1);
        chk("live_after_write", 32'(dout_s[0]), 32'h77);
`endif

        op(1, 0, 8'h00, 1, 8'h50, 8'h12, 1);
        op(1, 0, 8'h00, 1, 8'hC7, 8'h34, 1);
        op(1, 0, 8'h00, 1, 8'hD0, 8'hFF, 1);
        op(1, 0, 8'h00, 1, 8'hC8, 8'hEE, 1);
        op(1, 1, 8'hD0, 0, 8'h00, 8'h00, 1);
        op(1, 1, 8'hC8, 0, 8'h00, 8'h00, 1);
        op(1, 1, 8'h50, 0, 8'h00, 8'h00, 1);
        op(1, 1, 8'hC7, 0, 8'h00, 8'h00, 1);
        idle(3);

        for (int a = 0; a < 256; a++) op(0, 0, 8'h00, 1, 8'(a), 8'(a) ^ 8'h5A, 1);
        idle(3);
        max0 = 0;
        for (int a = 0; a < 256; a++)
            op(0, 1, 8'(a), 1, 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 1);
        idle(LAT + 4);

        chk("vld_run_256", 32'(max0), 32'd256);
        for (int g = 0; g < N; g++)
            chk($sformatf("sb_drained[%0d]", g), 32'(sb[g].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
